i2c_frame_tx: RTL
=================

I2C_FRAME_TX -- requirements
Module: i2c_frame_tx

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4, i_clk cycles per SCLK half-period; legal values >= 2.
REQ-002 SHALL have port i_clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_valid  input  1  frame request; transfer occurs on a cycle with i_valid=1 and o_ready=1.
REQ-005 SHALL have port i_data  input  24  frame; [23:16] slave addr + R/W, [15:8] byte 2, [7:0] byte 3; sent MSB first.
REQ-006 SHALL have port o_ready  output  1  high only in IDLE.
REQ-007 SHALL have port o_done  output  1  one-cycle pulse when a frame (complete or aborted) ends.
REQ-008 SHALL have port o_ack_err  output  1  set if any ACK slot in the last frame sampled high.
REQ-009 SHALL have port i_sdat  input  1  SDA bus value, read only in ACK slots.
REQ-010 SHALL have port o_sclk  output  1  SCL.
REQ-011 SHALL have port o_sdat  output  1  SDA drive value.
REQ-012 SHALL have port o_oen  output  1  1 = drive o_sdat onto SDA; 0 = release SDA.

Function
REQ-013 SHALL implement states IDLE, START, BIT, ACK, STOP, DONE.
REQ-014 IDLE: o_sclk=1, o_sdat=1, o_oen=1, o_ready=1; on transfer, latch i_data, clear o_ack_err, go to START.
REQ-015 START: o_sclk=1, o_sdat=0 for HALF_PERIOD cycles, then BIT at bit 23.
REQ-016 BIT: low phase (o_sclk=0, o_sdat=current bit) for HALF_PERIOD cycles, then high phase (o_sclk=1, o_sdat held) for HALF_PERIOD cycles; SDA changes only while o_sclk=0.
REQ-017 After each 8th bit of a byte, SHALL enter ACK: o_oen=0, low phase then high phase, HALF_PERIOD cycles each.
REQ-018 ACK SHALL sample i_sdat on the last cycle of its high phase; 1 sets o_ack_err (sticky until next transfer).
REQ-019 After ACK of bytes 1 and 2, SHALL continue in BIT; after ACK of byte 3, SHALL go to STOP.
REQ-020 STOP: o_oen=1 throughout; phase 1 o_sclk=0, o_sdat=0; phase 2 o_sclk=1, o_sdat=0; phase 3 o_sclk=1, o_sdat=1; HALF_PERIOD cycles each; then DONE.
REQ-021 DONE: o_done=1 for exactly one cycle, o_ready=0, bus outputs as IDLE; next state IDLE.
REQ-022 Full frame SHALL last 58*HALF_PERIOD cycles from the transfer edge to DONE entry; o_done is high in cycle 58*HALF_PERIOD+1 after transfer (233 for default).
REQ-023 i_valid and i_data SHALL be ignored while o_ready=0; with i_valid held high, the next transfer occurs in the cycle after o_done.
REQ-024 Phase counter SHALL count 0..HALF_PERIOD-1 and wrap; bit index 0..7 and byte index 0..2 SHALL NOT wrap past the frame.

Reset
REQ-025 While i_rst_n=0: state IDLE, counters 0, o_sclk=1, o_sdat=1, o_oen=1, o_ready=1, o_done=0, o_ack_err=0.
REQ-026 Reset asserted mid-frame SHALL abort immediately with no STOP generation and no o_done pulse; the latched frame is discarded.

Configuration
REQ-027 Macro I2C_ACK_ABORT_EN defined: an ACK slot sampling 1 SHALL skip remaining bytes and go directly to STOP, then DONE.
REQ-028 Macro I2C_ACK_ABORT_EN undefined: NACK SHALL only set o_ack_err; all 3 bytes are always sent (REQ-022 timing).

Verification
REQ-029 i_data=24'h34_1E_00, i_sdat=0 in all ACK slots -> SDA bits 0011_0100 0001_1110 0000_0000 at SCL rising edges, o_done in cycle 233, o_ack_err=0.
REQ-030 i_data=24'h34_0E_42, i_sdat=1 in first ACK slot, I2C_ACK_ABORT_EN defined -> STOP after byte 1, o_done in cycle 89, o_ack_err=1.
REQ-031 Same stimulus as REQ-030 with I2C_ACK_ABORT_EN undefined -> all 27 bit/ACK slots sent, o_done in cycle 233, o_ack_err=1.
REQ-032 i_valid held high, frames 24'h34_12_01 then 24'h34_0C_00 -> second transfer in the cycle after first o_done; second frame's o_ack_err reflects only its own ACK slots.
REQ-033 i_rst_n pulsed low at cycle 100 of a frame -> outputs 1/1/1 within the reset, no o_done, o_ready=1 after release.
REQ-034 i_valid pulsed at cycle 50 of a frame with i_data=24'hFFFFFF -> ignored; SDA bit pattern of the active frame unchanged.

Source files
------------

// File: rtl/i2c_frame_tx.sv
// i2c_frame_tx: transmits one 3-byte I2C write frame (address+R/W, two data
// bytes) with START, per-byte ACK slots and STOP. All outputs are registered.
// Optional build macro I2C_ACK_ABORT_EN: a NACK ends the frame early with STOP.
module i2c_frame_tx #(
    parameter int HALF_PERIOD = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [23:0] i_data,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_ack_err,
    input  logic        i_sdat,
    output logic        o_sclk,
    output logic        o_sdat,
    output logic        o_oen
);

    localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;       // cycles spent in the current half-period
    logic [1:0]        phase_reg;     // BIT/ACK: 0 low, 1 high; STOP: 0..2
    logic [2:0]        bit_idx_reg;   // bit within the current byte
    logic [1:0]        byte_idx_reg;  // byte within the frame
    logic [23:0]       shift_reg;     // frame, current bit always at [23]

    logic phase_end;
    logic ack_to_stop;

    assign phase_end = (cnt_reg == CNT_LAST);

`ifdef I2C_ACK_ABORT_EN
    // A NACK (SDA high in the sample cycle) cuts the frame short.
    assign ack_to_stop = (byte_idx_reg == 2'd2) || i_sdat;
`else
    // NACK only flags the error; all three bytes are always sent.
    assign ack_to_stop = (byte_idx_reg == 2'd2);
`endif

    // Frame sequencer: state, counters and registered bus/handshake outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            phase_reg    <= 2'd0;
            bit_idx_reg  <= 3'd0;
            byte_idx_reg <= 2'd0;
            shift_reg    <= 24'd0;
            o_sclk       <= 1'b1;
            o_sdat       <= 1'b1;
            o_oen        <= 1'b1;
            o_ready      <= 1'b1;
            o_done       <= 1'b0;
            o_ack_err    <= 1'b0;
        end else begin
            if (state_reg == S_START || state_reg == S_BIT ||
                state_reg == S_ACK   || state_reg == S_STOP) begin
                cnt_reg <= phase_end ? '0 : cnt_reg + 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (i_valid) begin
                        shift_reg <= i_data;
                        o_ack_err <= 1'b0;
                        o_ready   <= 1'b0;
                        o_sdat    <= 1'b0;   // SDA falls while SCL high: START
                        cnt_reg   <= '0;
                        state_reg <= S_START;
                    end
                end

                S_START: begin
                    if (phase_end) begin
                        phase_reg    <= 2'd0;
                        bit_idx_reg  <= 3'd0;
                        byte_idx_reg <= 2'd0;
                        o_sclk       <= 1'b0;
                        o_sdat       <= shift_reg[23];
                        state_reg    <= S_BIT;
                    end
                end

                S_BIT: begin
                    if (phase_end) begin
                        if (phase_reg == 2'd0) begin
                            phase_reg <= 2'd1;
                            o_sclk    <= 1'b1;
                        end else begin
                            shift_reg <= {shift_reg[22:0], 1'b0};
                            phase_reg <= 2'd0;
                            o_sclk    <= 1'b0;
                            if (bit_idx_reg == 3'd7) begin
                                bit_idx_reg <= 3'd0;
                                o_oen       <= 1'b0;
                                o_sdat      <= 1'b1;
                                state_reg   <= S_ACK;
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                                // next bit is [22] until the shift lands
                                o_sdat      <= shift_reg[22];
                            end
                        end
                    end
                end

                S_ACK: begin
                    if (phase_end) begin
                        if (phase_reg == 2'd0) begin
                            phase_reg <= 2'd1;
                            o_sclk    <= 1'b1;
                        end else begin
                            if (i_sdat) begin
                                o_ack_err <= 1'b1;
                            end
                            phase_reg <= 2'd0;
                            o_sclk    <= 1'b0;
                            o_oen     <= 1'b1;
                            if (ack_to_stop) begin
                                o_sdat    <= 1'b0;
                                state_reg <= S_STOP;
                            end else begin
                                byte_idx_reg <= byte_idx_reg + 2'd1;
                                o_sdat       <= shift_reg[23];
                                state_reg    <= S_BIT;
                            end
                        end
                    end
                end

                S_STOP: begin
                    if (phase_end) begin
                        if (phase_reg == 2'd0) begin
                            phase_reg <= 2'd1;
                            o_sclk    <= 1'b1;
                        end else if (phase_reg == 2'd1) begin
                            phase_reg <= 2'd2;
                            o_sdat    <= 1'b1;   // SDA rises while SCL high: STOP
                        end else begin
                            phase_reg <= 2'd0;
                            o_done    <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    o_done    <= 1'b0;
                    o_ready   <= 1'b1;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
